// File: rtl/iddmm_result_drain.sv
// iddmm_result_drain
//   Consumer end of the iddmm_cal result write port. Mirrors every result word
//   into a local N x K buffer and, on fin_start, performs the Montgomery final
//   conditional subtraction (a + carry*2^(K*N) - p when that is >= p) one word
//   per cycle. The N-word result is then streamed LSW first on a valid/ready
//   master port.
//
//   Build option: IDDMM_FINAL_SUB_EN
//     defined   - full reduction path (modulus read, subtractor, SUB state)
//     undefined - no subtractor; fin_start goes straight to OUT and a_buf is
//                 streamed unreduced; p_rd_addr is tied to 0
//
//   Ports
//     clk, rst               clock, synchronous active-high reset
//     wr_a_en/addr/data      result word writes from iddmm_cal (taken in IDLE only)
//     fin_start, fin_carry   start final reduction, top carry of the result
//     p_rd_addr, p_rd_data   modulus RAM read port (1-cycle read latency)
//     m_valid/ready/data     output stream, LSW first
//     m_last                 marks word N-1
//     busy                   high in SUB and OUT
//     wr_drop                sticky: a write was discarded while busy
//
//   state  | meaning
//   IDLE   | accept result writes, wait for fin_start
//   SUB    | read p word by word, build d_buf = a - p with ripple borrow
//   OUT    | stream d_buf or a_buf depending on the final borrow and carry

module iddmm_result_drain #(
   parameter int K      = 128,
   parameter int N      = 32,
   parameter int ADDR_W = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_a_en,
   input  logic [ADDR_W:0]   wr_a_addr,
   input  logic [K-1:0]      wr_a_data,
   input  logic              fin_start,
   input  logic              fin_carry,
   output logic [ADDR_W:0]   p_rd_addr,
   input  logic [K-1:0]      p_rd_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [K-1:0]      m_data,
   output logic              m_last,
   output logic              busy,
   output logic              wr_drop
);

   localparam logic [ADDR_W:0] N_IDX    = (ADDR_W+1)'(N);
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(N-1);

`ifdef IDDMM_FINAL_SUB_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SUB = 2'd1, S_OUT = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_OUT = 2'd2} state_t;
`endif

   state_t            state, state_nx;
   logic [ADDR_W:0]   idx;
   logic [K-1:0]      a_buf [N];
   logic              wr_ok;
   logic [ADDR_W-1:0] out_sel;

   assign wr_ok   = !rst && wr_a_en && (state == S_IDLE) && (wr_a_addr < N_IDX);
   assign out_sel = idx[ADDR_W-1:0];

`ifdef IDDMM_FINAL_SUB_EN
   logic [K-1:0]      d_buf [N];
   logic [ADDR_W:0]   p_rd_q;
   logic              borrow;
   logic              carry_q;
   logic              use_diff;
   logic [ADDR_W-1:0] sub_sel;
   logic [K:0]        sub_full;
   logic              sub_bo;

   // In SUB, idx counts cycles since entry; the word returning from the
   // modulus RAM belongs to the address issued one cycle earlier (idx-1).
   // At idx == N the low bits wrap to N-1, which is exactly the last word.
   assign sub_sel   = idx[ADDR_W-1:0] - 1'b1;
   assign sub_full  = {1'b0, a_buf[sub_sel]} - {1'b0, p_rd_data} - {{K{1'b0}}, borrow};
   assign sub_bo    = sub_full[K];
   assign p_rd_addr = p_rd_q;
`else
   logic unused_in;
   assign unused_in = ^{fin_carry, p_rd_data};
   assign p_rd_addr = '0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // next state
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (fin_start) begin
`ifdef IDDMM_FINAL_SUB_EN
            state_nx = S_SUB;
`else
            state_nx = S_OUT;
`endif
         end
`ifdef IDDMM_FINAL_SUB_EN
         S_SUB:  if (idx == N_IDX) state_nx = S_OUT;
`endif
         S_OUT:  if (m_ready && (idx == LAST_IDX)) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // outputs
   always_comb begin
      busy    = (state != S_IDLE);
      m_valid = (state == S_OUT);
      m_last  = m_valid && (idx == LAST_IDX);
      m_data  = '0;
      if (m_valid) begin
`ifdef IDDMM_FINAL_SUB_EN
         m_data = use_diff ? d_buf[out_sel] : a_buf[out_sel];
`else
         m_data = a_buf[out_sel];
`endif
      end
   end

   // control datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         idx     <= '0;
         wr_drop <= 1'b0;
`ifdef IDDMM_FINAL_SUB_EN
         p_rd_q   <= '0;
         borrow   <= 1'b0;
         carry_q  <= 1'b0;
         use_diff <= 1'b0;
`endif
      end else begin
         if (busy && wr_a_en) wr_drop <= 1'b1;
         case (state)
            S_IDLE: if (fin_start) begin
               idx     <= '0;
               wr_drop <= 1'b0;
`ifdef IDDMM_FINAL_SUB_EN
               p_rd_q  <= '0;
               borrow  <= 1'b0;
               carry_q <= fin_carry;
`endif
            end
`ifdef IDDMM_FINAL_SUB_EN
            S_SUB: begin
               p_rd_q <= (idx < LAST_IDX) ? idx + 1'b1 : '0;
               if (idx != '0) borrow <= sub_bo;
               if (idx == N_IDX) begin
                  idx      <= '0;
                  use_diff <= carry_q | ~sub_bo;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
`endif
            S_OUT: if (m_ready && (idx != LAST_IDX)) idx <= idx + 1'b1;
            default: ;
         endcase
      end
   end

   // word buffers, intentionally not cleared by reset
   always_ff @(posedge clk) begin
      if (wr_ok) a_buf[wr_a_addr[ADDR_W-1:0]] <= wr_a_data;
`ifdef IDDMM_FINAL_SUB_EN
      if ((state == S_SUB) && (idx != '0)) d_buf[sub_sel] <= sub_full[K-1:0];
`endif
   end

endmodule

// File: tb/tb_iddmm_result_drain.sv
module tb_iddmm_result_drain;
   localparam int K  = 8;
   localparam int N  = 4;
   localparam int AW = 2;
`ifdef IDDMM_FINAL_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif
   localparam int LAT = SUB_EN ? N + 2 : 1;

   logic          clk = 1'b0;
   logic          rst, wr_a_en, fin_start, fin_carry, m_ready;
   logic          m_valid, m_last, busy, wr_drop;
   logic [AW:0]   wr_a_addr, p_rd_addr;
   logic [K-1:0]  wr_a_data, p_rd_data, m_data;
   logic [K-1:0]  p_mem [N];

   int vectors     = 0;
   int miscompares = 0;

   iddmm_result_drain #(.K(K), .N(N), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .wr_a_en(wr_a_en), .wr_a_addr(wr_a_addr), .wr_a_data(wr_a_data),
      .fin_start(fin_start), .fin_carry(fin_carry),
      .p_rd_addr(p_rd_addr), .p_rd_data(p_rd_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .wr_drop(wr_drop)
   );

   always #5 clk = ~clk;

   // modulus RAM, one-cycle read latency
   always @(posedge clk) p_rd_data <= p_mem[p_rd_addr[AW-1:0]];

   // reference: whole-number view of the final subtraction
   function automatic logic [31:0] ref_out(input logic [31:0] a, input logic [31:0] p,
                                           input logic c);
      logic [32:0] full;
      full = {c, a};
      if (SUB_EN && (full >= {1'b0, p})) begin
         full = full - {1'b0, p};
         return full[31:0];
      end
      return a;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a(input logic [31:0] a);
      for (int i = 0; i < N; i++) begin
         wr_a_en   = 1'b1;
         wr_a_addr = (AW+1)'(i);
         wr_a_data = a[8*i +: 8];
         tick();
      end
      wr_a_en = 1'b0;
   endtask

   task automatic set_p(input logic [31:0] p);
      for (int i = 0; i < N; i++) p_mem[i] = p[8*i +: 8];
   endtask

   // Pulses fin_start, checks the modulus address sequence and first-valid
   // latency, then consumes n_words with per-word stall counts (2 bits each).
   // With poke set, a write and a stray fin_start are issued during word 2.
   task automatic run_stream(input logic [31:0] expw, input logic carry,
                             input logic [7:0] stalls, input bit poke,
                             input int n_words, input string nm);
      int          cnt;
      bit          ok;
      logic [AW:0] exp_addr;
      logic        lastx;
      fin_start = 1'b1;
      fin_carry = carry;
      m_ready   = 1'b0;
      cnt = 0;
      ok  = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         fin_start = 1'b0;
         fin_carry = 1'b0;
         wr_a_en   = 1'b0;
         cnt++;
         if (cnt <= N) begin
            exp_addr = SUB_EN ? (AW+1)'(cnt - 1) : '0;
            vectors++;
            if (p_rd_addr !== exp_addr) begin
               miscompares++;
               $display("FAIL %s p_rd_addr cyc%0d: got %0d want %0d", nm, cnt, p_rd_addr, exp_addr);
            end
         end
         if (m_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      vectors++;
      if (!ok || cnt != LAT) begin
         miscompares++;
         $display("FAIL %s latency: got %0d (valid seen %0d) want %0d", nm, cnt, ok, LAT);
      end
      if (!ok) return;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s busy in OUT: got %b want 1", nm, busy);
      end
      for (int w = 0; w < n_words; w++) begin
         lastx = (w == N - 1);
         for (int s = 0; s < int'(stalls[2*w +: 2]); s++) begin
            vectors++;
            if ({m_valid, m_data, m_last} !== {1'b1, expw[8*w +: 8], lastx}) begin
               miscompares++;
               $display("FAIL %s stall w%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                        nm, w, m_valid, m_data, m_last, expw[8*w +: 8], lastx);
            end
            tick();
         end
         m_ready = 1'b1;
         if (poke && w == 2) begin
            wr_a_en   = 1'b1;
            wr_a_addr = '0;
            wr_a_data = ~expw[7:0];
            fin_start = 1'b1;
            fin_carry = ~carry;
         end
         vectors++;
         if ({m_valid, m_data, m_last} !== {1'b1, expw[8*w +: 8], lastx}) begin
            miscompares++;
            $display("FAIL %s word%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     nm, w, m_valid, m_data, m_last, expw[8*w +: 8], lastx);
         end
         tick();
         m_ready   = 1'b0;
         wr_a_en   = 1'b0;
         fin_start = 1'b0;
         fin_carry = 1'b0;
      end
      if (n_words == N) begin
         vectors++;
         if ({m_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL %s end: got valid=%b busy=%b want 0 0", nm, m_valid, busy);
         end
         vectors++;
         if (wr_drop !== poke) begin
            miscompares++;
            $display("FAIL %s wr_drop: got %b want %b", nm, wr_drop, poke);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      vectors++;
      if ({m_valid, m_data, m_last, busy, wr_drop, p_rd_addr} !== '0) begin
         miscompares++;
         $display("FAIL reset: got v=%b d=%h l=%b busy=%b drop=%b paddr=%0d want all 0",
                  m_valid, m_data, m_last, busy, wr_drop, p_rd_addr);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_vectors();
      set_p(32'h01000003); load_a(32'h01000005);
      run_stream(SUB_EN ? 32'h00000002 : 32'h01000005, 1'b0, 8'h00, 1'b0, N, "vec_sub");
      set_p(32'h01000003); load_a(32'h00FFFFFF);
      run_stream(32'h00FFFFFF, 1'b0, 8'h00, 1'b0, N, "vec_borrow");
      set_p(32'hFFFFFFF3); load_a(32'h00000001);
      run_stream(SUB_EN ? 32'h0000000E : 32'h00000001, 1'b1, 8'h00, 1'b0, N, "vec_carry");
      set_p(32'h12345678); load_a(32'h12345678);
      run_stream(SUB_EN ? 32'h00000000 : 32'h12345678, 1'b0, 8'h00, 1'b0, N, "vec_equal");
   endtask

   task automatic test_stall();
      set_p(32'h01000003); load_a(32'h01000005);
      run_stream(ref_out(32'h01000005, 32'h01000003, 1'b0), 1'b0, 8'h0C, 1'b0, N, "stall");
   endtask

   task automatic test_write_drop();
      logic [31:0] a, p, e;
      a = 32'h5A3C9F10; p = 32'h2B7711EE;
      e = ref_out(a, p, 1'b0);
      set_p(p); load_a(a);
      run_stream(e, 1'b0, 8'h00, 1'b1, N, "drop_poke");
      // buffer must be untouched and wr_drop cleared by the next fin_start
      run_stream(e, 1'b0, 8'h00, 1'b0, N, "drop_rerun");
   endtask

   task automatic test_addr_and_start_write();
      logic [31:0] a, p;
      a = 32'h8844CC22; p = 32'h33221100;
      set_p(p);
      for (int i = 0; i < N - 1; i++) begin
         wr_a_en = 1'b1; wr_a_addr = (AW+1)'(i); wr_a_data = a[8*i +: 8]; tick();
      end
      for (int i = N; i < 2*N; i++) begin
         wr_a_en = 1'b1; wr_a_addr = (AW+1)'(i); wr_a_data = 8'hEE; tick();
      end
      // last word is written in the same cycle as fin_start
      wr_a_en = 1'b1; wr_a_addr = (AW+1)'(N-1); wr_a_data = a[31:24];
      run_stream(ref_out(a, p, 1'b0), 1'b0, 8'h00, 1'b0, N, "start_write");
   endtask

   task automatic test_mid_reset();
      logic [31:0] a, p, e;
      a = 32'hC0FFEE11; p = 32'h0BADF00D;
      e = ref_out(a, p, 1'b0);
      set_p(p); load_a(a);
      run_stream(e, 1'b0, 8'h00, 1'b0, 2, "mid_rst_a");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if ({m_valid, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL mid_rst: got valid=%b busy=%b want 0 0", m_valid, busy);
      end
      run_stream(e, 1'b0, 8'h00, 1'b0, N, "mid_rst_b");
   endtask

   task automatic test_random();
      logic [31:0] a, p;
      logic        c;
      for (int n = 0; n < 30; n++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: p = a;
            1: p = a + 32'($urandom_range(0, 2)) - 32'd1;
            default: p = $urandom;
         endcase
         c = 1'($urandom_range(0, 1));
         set_p(p); load_a(a);
         run_stream(ref_out(a, p, c), c, 8'($urandom), 1'b0, N, "random");
      end
   endtask

   initial begin
      rst = 1'b1; wr_a_en = 1'b0; wr_a_addr = '0; wr_a_data = '0;
      fin_start = 1'b0; fin_carry = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < N; i++) p_mem[i] = '0;
      test_reset();
      test_vectors();
      test_stall();
      test_write_drop();
      test_addr_and_start_write();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
